// File: rtl/led_share_arbiter.sv
// Round-robin owner of the 3-bit LED bank: each grant is shown for a minimum dwell,
// then the LEDs are blanked for a gap before the next owner is displayed.
module led_share_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DWELL_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES   = 2000000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                       SYS_CLK,
  input  logic                       RESET,
  input  logic [NUM_REQ-1:0]         REQ,
  input  logic [3*NUM_REQ-1:0]       PAT,
  output logic [NUM_REQ-1:0]         GRANT,
  output logic [$clog2(NUM_REQ)-1:0] OWNER,
  output logic [2:0]                 LED,
  output logic                       BUSY
);

  localparam int unsigned OW_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [OW_W-1:0]    owner_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [2:0]         led_nxt;
  // Cleared by reset so the very first search starts at requester 0 while OWNER reads 0.
  logic               started, started_nxt;

  logic [OW_W-1:0]    start_idx;
  logic               hi_vld, lo_vld, pick_vld;
  logic [OW_W-1:0]    hi_idx, lo_idx, pick_idx;
  logic [2:0]         pick_pat, own_pat;
  logic               own_req, other_req;
  logic               take_pick;

  function automatic logic [2:0] pat_at(input logic [3*NUM_REQ-1:0] p,
                                        input logic [OW_W-1:0]      idx);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (idx == OW_W'(i)) r = p[3*i +: 3];
    end
    return r;
  endfunction

  always_comb begin
    if (!started || OWNER == OW_W'(NUM_REQ - 1)) start_idx = '0;
    else                                         start_idx = OWNER + 1'b1;
  end

  // Wrapping search split in two: first hit at/after start_idx, else first hit overall.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (REQ[i] && !lo_vld) begin
        lo_vld = 1'b1;
        lo_idx = OW_W'(i);
      end
      if (REQ[i] && !hi_vld && i >= 32'(start_idx)) begin
        hi_vld = 1'b1;
        hi_idx = OW_W'(i);
      end
    end
  end

  assign pick_vld  = hi_vld | lo_vld;
  assign pick_idx  = hi_vld ? hi_idx : lo_idx;
  assign pick_pat  = pat_at(PAT, pick_idx);
  assign own_pat   = pat_at(PAT, OWNER);
  assign own_req   = (REQ & GRANT) != '0;
  assign other_req = (REQ & ~GRANT) != '0;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    owner_nxt   = OWNER;
    grant_nxt   = GRANT;
    led_nxt     = LED;
    started_nxt = started;
    take_pick   = 1'b0;

    case (state)
      ST_IDLE: take_pick = 1'b1;

      ST_HOLD: begin
        if (!own_req || (cnt == DWELL_LAST && other_req)) begin
          if (GAP_CYCLES == 0) begin
            take_pick = 1'b1;
          end else begin
            state_nxt = ST_GAP;
            cnt_nxt   = '0;
            grant_nxt = '0;
            led_nxt   = '0;
          end
        end else begin
          if (cnt != DWELL_LAST) cnt_nxt = cnt + 1'b1;
          led_nxt = own_pat;
        end
      end

      ST_GAP: begin
        if (cnt == GAP_LAST) take_pick = 1'b1;
        else                 cnt_nxt   = cnt + 1'b1;
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        grant_nxt = '0;
        led_nxt   = '0;
      end
    endcase

    if (take_pick) begin
      cnt_nxt = '0;
      if (pick_vld) begin
        state_nxt           = ST_HOLD;
        owner_nxt           = pick_idx;
        grant_nxt           = '0;
        grant_nxt[pick_idx] = 1'b1;
        led_nxt             = pick_pat;
        started_nxt         = 1'b1;
      end else begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        led_nxt   = '0;
      end
    end
  end

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      OWNER   <= '0;
      GRANT   <= '0;
      LED     <= '0;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      OWNER   <= owner_nxt;
      GRANT   <= grant_nxt;
      LED     <= led_nxt;
      started <= started_nxt;
    end
  end

  assign BUSY = (state != ST_IDLE);

  a_grant_onehot0: assert property (@(posedge SYS_CLK) disable iff (RESET) $onehot0(GRANT));
  a_blank_led:     assert property (@(posedge SYS_CLK) disable iff (RESET)
                                    (GRANT == '0) |-> (LED == 3'b000));

endmodule
